md_pad_scanner: RTL and testbench

- Physical-side reader for the DB9 joystick port: drives the SELECT line and samples the six pad pins.
- Decodes Atari-style single-fire sticks and Sega Mega Drive 3/6-button pads.
- Produces the active-low FUDLR vector consumed by the joystick protocol block (its db9joy_in), plus an extended button word for ZXUNO registers.
- Sits between the DB9 pins and the joystick protocol logic.

---
 rtl/md_pad_scanner.sv | 158 +++++++++++++++
 tb/tb_md_pad_scanner.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/md_pad_scanner.sv
// DB9 pad scanner: drives SELECT, decodes Atari sticks and Mega Drive 3/6-button pads.
// Define MD_SIXBTN_EN to enable the full 8-phase sequence with 6-button decoding.
module md_pad_scanner #(
  parameter int PHASE_CYCLES = 224,
  parameter int IDLE_CYCLES  = 56000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  joy_pins,
  output logic        joy_sel,
  output logic [4:0]  db9joy_out,
  output logic [11:0] buttons,
  output logic        md_present,
  output logic        six_button,
  output logic        scan_done
);

  localparam int CNT_MAX = (IDLE_CYCLES > PHASE_CYCLES) ? IDLE_CYCLES : PHASE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);

  typedef enum logic [3:0] {
    ST_IDLE, ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6, ST_S7, ST_COMMIT
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [5:0]     sync1_q, sync2_q;
  logic [7:0]     cap_q, cap_d;
  logic           md_det_q, md_det_d;
  logic           sel_q, sel_d;
  logic [4:0]     db9_q, db9_d;
  logic [11:0]    buttons_q, buttons_d;
  logic           md_present_q, md_present_d;
  logic           scan_done_q, scan_done_d;
  logic           phase_end, idle_end;
`ifdef MD_SIXBTN_EN
  logic [3:0]     ext_q, ext_d;
  logic           six_det_q, six_det_d;
  logic           six_button_q, six_button_d;
`endif

  assign phase_end = (cnt_q == CW'(PHASE_CYCLES - 1));
  assign idle_end  = (cnt_q == CW'(IDLE_CYCLES - 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    cap_d        = cap_q;
    md_det_d     = md_det_q;
    db9_d        = db9_q;
    buttons_d    = buttons_q;
    md_present_d = md_present_q;
    scan_done_d  = 1'b0;
`ifdef MD_SIXBTN_EN
    ext_d        = ext_q;
    six_det_d    = six_det_q;
    six_button_d = six_button_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (idle_end) begin
          state_d = ST_S0;
          cnt_d   = '0;
        end
      end
      ST_COMMIT: begin
        state_d      = ST_IDLE;
        cnt_d        = '0;
        scan_done_d  = 1'b1;
        md_present_d = md_det_q;
        // Atari sticks keep c as fire-2; MD-only buttons are masked off.
        buttons_d[7:0]  = md_det_q ? cap_q : {2'b00, cap_q[5:0]};
        buttons_d[11:8] = 4'b0000;
`ifdef MD_SIXBTN_EN
        buttons_d[11:8] = six_det_q ? ext_q : 4'b0000;
        six_button_d    = six_det_q;
`endif
        db9_d = ~{cap_q[4], cap_q[0], cap_q[1], cap_q[2], cap_q[3]};
      end
      default: begin
        if (phase_end) begin
          cnt_d = '0;
          case (state_q)
            ST_S0: cap_d[5:0] = ~sync2_q;
            ST_S1: begin
              cap_d[6] = ~sync2_q[4];
              cap_d[7] = ~sync2_q[5];
              md_det_d = ~sync2_q[2] & ~sync2_q[3];
            end
`ifdef MD_SIXBTN_EN
            ST_S5: six_det_d = md_det_q & (sync2_q[3:0] == 4'b0000);
            ST_S6: if (six_det_q) ext_d = ~sync2_q[3:0];
`endif
            default: ;
          endcase
`ifdef MD_SIXBTN_EN
          state_d = (state_q == ST_S7) ? ST_COMMIT : state_t'(state_q + 4'd1);
`else
          state_d = (state_q == ST_S1) ? ST_COMMIT : ST_S1;
`endif
        end
      end
    endcase

    sel_d = !(state_d inside {ST_S1, ST_S3, ST_S5, ST_S7});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sync1_q      <= 6'h3F;
      sync2_q      <= 6'h3F;
      cap_q        <= '0;
      md_det_q     <= 1'b0;
      sel_q        <= 1'b1;
      db9_q        <= 5'h1F;
      buttons_q    <= '0;
      md_present_q <= 1'b0;
      scan_done_q  <= 1'b0;
`ifdef MD_SIXBTN_EN
      ext_q        <= '0;
      six_det_q    <= 1'b0;
      six_button_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sync1_q      <= joy_pins;
      sync2_q      <= sync1_q;
      cap_q        <= cap_d;
      md_det_q     <= md_det_d;
      sel_q        <= sel_d;
      db9_q        <= db9_d;
      buttons_q    <= buttons_d;
      md_present_q <= md_present_d;
      scan_done_q  <= scan_done_d;
`ifdef MD_SIXBTN_EN
      ext_q        <= ext_d;
      six_det_q    <= six_det_d;
      six_button_q <= six_button_d;
`endif
    end
  end

  assign joy_sel    = sel_q;
  assign db9joy_out = db9_q;
  assign buttons    = buttons_q;
  assign md_present = md_present_q;
  assign scan_done  = scan_done_q;
`ifdef MD_SIXBTN_EN
  assign six_button = six_button_q;
`else
  assign six_button = 1'b0;
`endif

endmodule

// File: tb/tb_md_pad_scanner.sv
// Testbench for md_pad_scanner: pad models on the DB9 pins, scoreboard of expected scan results.
module tb_md_pad_scanner;

  localparam int P = 8;
  localparam int I = 40;
`ifdef MD_SIXBTN_EN
  localparam bit SIX_EN = 1'b1;
  localparam int PHASES = 8;
`else
  localparam bit SIX_EN = 1'b0;
  localparam int PHASES = 2;
`endif
  localparam int PERIOD = I + PHASES * P + 1;
  localparam int FALLS  = PHASES / 2;

  localparam logic [1:0] PAD_NONE  = 2'd0;
  localparam logic [1:0] PAD_ATARI = 2'd1;
  localparam logic [1:0] PAD_MD3   = 2'd2;
  localparam logic [1:0] PAD_MD6   = 2'd3;

  typedef struct packed {
    logic [11:0] buttons;
    logic [4:0]  db9;
    logic        md;
    logic        six;
  } expect_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  joyPins;
  logic        joy_sel;
  logic [4:0]  db9joy_out;
  logic [11:0] buttons;
  logic        md_present;
  logic        six_button;
  logic        scan_done;

  logic [1:0]  padType = PAD_NONE;
  logic [11:0] padBtn  = 12'h000;
  int          lowCount = 0;
  int          highRun  = 0;
  logic        prevSel  = 1'b1;

  int          errors = 0;
  int          checks = 0;
  expect_t     sbQueue[$];

  md_pad_scanner #(.PHASE_CYCLES(P), .IDLE_CYCLES(I)) dut (
    .clk        (clk),
    .rst        (rst),
    .joy_pins   (joyPins),
    .joy_sel    (joy_sel),
    .db9joy_out (db9joy_out),
    .buttons    (buttons),
    .md_present (md_present),
    .six_button (six_button),
    .scan_done  (scan_done)
  );

  always #5 clk = ~clk;

  // A real 6-button pad counts SELECT falls and resets its counter after a long high period.
  always @(posedge clk) begin
    prevSel <= joy_sel;
    if (joy_sel) highRun <= highRun + 1;
    else         highRun <= 0;
    if (highRun > 20)                lowCount <= 0;
    else if (prevSel && !joy_sel)    lowCount <= lowCount + 1;
  end

  always_comb begin
    joyPins = 6'h3F;
    case (padType)
      PAD_ATARI: joyPins = ~padBtn[5:0];
      PAD_MD3, PAD_MD6: begin
        if (joy_sel) begin
          if (padType == PAD_MD6 && lowCount == 3)
            joyPins = {~padBtn[5], ~padBtn[4], ~padBtn[11], ~padBtn[10], ~padBtn[9], ~padBtn[8]};
          else
            joyPins = ~padBtn[5:0];
        end else begin
          if (padType == PAD_MD6 && lowCount == 3)
            joyPins = {~padBtn[7], ~padBtn[6], 4'b0000};
          else if (padType == PAD_MD6 && lowCount >= 4)
            joyPins = {~padBtn[7], ~padBtn[6], 4'b1111};
          else
            joyPins = {~padBtn[7], ~padBtn[6], 2'b00, ~padBtn[1], ~padBtn[0]};
        end
      end
      default: ;
    endcase
  end

  function automatic expect_t expectScan(logic [1:0] kind, logic [11:0] btn);
    expect_t e;
    e.buttons = 12'h000;
    e.md      = 1'b0;
    e.six     = 1'b0;
    case (kind)
      PAD_ATARI: e.buttons = btn & 12'h03F;
      PAD_MD3: begin
        e.buttons = btn & 12'h0FF;
        e.md      = 1'b1;
      end
      PAD_MD6: begin
        e.md = 1'b1;
        if (SIX_EN) begin
          e.buttons = btn;
          e.six     = 1'b1;
        end else begin
          e.buttons = btn & 12'h0FF;
        end
      end
      default: ;
    endcase
    e.db9 = ~{e.buttons[4], e.buttons[0], e.buttons[1], e.buttons[2], e.buttons[3]};
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  task automatic waitScanDone(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!scan_done && cycles < 3 * PERIOD);
    if (!scan_done) begin
      checks++;
      errors++;
      $display("[TB] FAIL scan_timeout: observed=no scan_done expected=pulse within %0d cycles", 3 * PERIOD);
    end
  endtask

  task automatic compareScan(input string tag);
    expect_t e;
    if (sbQueue.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sbQueue.pop_front();
    checkOutput({tag, "_db9"},     {27'd0, db9joy_out}, {27'd0, e.db9});
    checkOutput({tag, "_buttons"}, {20'd0, buttons},    {20'd0, e.buttons});
    checkOutput({tag, "_md"},      {31'd0, md_present}, {31'd0, e.md});
    checkOutput({tag, "_six"},     {31'd0, six_button}, {31'd0, e.six});
  endtask

  task automatic applyStimulus(input string tag, input logic [1:0] kind, input logic [11:0] btn);
    int cyc;
    padType = kind;
    padBtn  = btn;
    waitScanDone(cyc);
    sbQueue.push_back(expectScan(kind, btn));
    waitScanDone(cyc);
    checkOutput({tag, "_period"}, cyc, PERIOD);
    compareScan(tag);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_sel"},       {31'd0, joy_sel},    32'd1);
    checkOutput({tag, "_db9"},       {27'd0, db9joy_out}, 32'h1F);
    checkOutput({tag, "_buttons"},   {20'd0, buttons},    32'd0);
    checkOutput({tag, "_md"},        {31'd0, md_present}, 32'd0);
    checkOutput({tag, "_six"},       {31'd0, six_button}, 32'd0);
    checkOutput({tag, "_scan_done"}, {31'd0, scan_done},  32'd0);
  endtask

  // Call on a scan_done cycle: profiles SELECT over exactly one scan period.
  task automatic measureSel();
    int   highFirst = 0;
    int   falls = 0;
    int   badLow = 0;
    int   runLow = 0;
    bit   seenFall = 1'b0;
    logic prev = joy_sel;
    for (int t = 0; t < PERIOD; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      if (joy_sel) begin
        if (!prev) begin
          if (runLow != P) badLow++;
          runLow = 0;
        end
        if (!seenFall) highFirst++;
      end else begin
        if (prev) begin
          falls++;
          seenFall = 1'b1;
        end
        runLow++;
      end
      prev = joy_sel;
    end
    @(posedge clk);
    #1;
    checkOutput("sel_window_end", {31'd0, scan_done}, 32'd1);
    checkOutput("sel_falls", falls, FALLS);
    checkOutput("sel_low_runs_bad", badLow, 0);
    checkOutput("sel_high_between", highFirst, I + P);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkResetState("reset");

    sbQueue.push_back(expectScan(PAD_NONE, 12'h000));
    waitScanDone(cyc);
    checkOutput("first_scan_latency", cyc, PERIOD);
    compareScan("nopad");

    applyStimulus("atari", PAD_ATARI, 12'h011);

    // Abort a scan part-way through and confirm the next full scan is timed from reset release.
    repeat (SIX_EN ? (I + 4 * P + 3) : (I + P + 3)) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkResetState("midscan_reset");
    sbQueue.push_back(expectScan(PAD_ATARI, 12'h011));
    waitScanDone(cyc);
    checkOutput("reset_scan_latency", cyc, PERIOD);
    compareScan("atari_after_reset");

    applyStimulus("md3", PAD_MD3, 12'h048);
    applyStimulus("md6_x_start", PAD_MD6, 12'h480);
    measureSel();
    applyStimulus("md6_zmode_c_down", PAD_MD6, 12'h922);
    applyStimulus("nopad_again", PAD_NONE, 12'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
